// File: rtl/ladybird_mem_arbiter.sv
// Round-robin I/D arbiter onto one memory port; an in-order ID FIFO routes responses back.
// Optional grant/stall counters are enabled with `define LADYBIRD_MEM_ARBITER_PERF_EN.
module ladybird_mem_arbiter #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            anrst,
  input  logic            i_req,
  output logic            i_gnt,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  output logic            d_gnt,
  input  logic [XLEN-1:0] d_addr,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  input  logic            m_gnt,
  output logic [XLEN-1:0] m_addr,
  output logic            m_we,
  output logic [3:0]      m_be,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_rvalid,
  input  logic [XLEN-1:0] m_rdata,
  output logic            err
`ifdef LADYBIRD_MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]     i_grant_cnt,
  output logic [31:0]     d_grant_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {ID_I = 1'b0, ID_D = 1'b1} id_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } req_t;

  id_e             fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  id_e             last_grant_q;
  id_e             sel;
  id_e             head;
  req_t            payload;
  logic            avail, handshake, pop, spurious;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Selection and payload mux; on conflict the requester not granted last wins.
  always_comb begin
    sel     = ID_I;
    payload = '{addr: i_addr, we: 1'b0, be: 4'hF, wdata: '0};
    if (d_req && (!i_req || last_grant_q == ID_I)) begin
      sel     = ID_D;
      payload = '{addr: d_addr, we: d_we, be: d_be, wdata: d_wdata};
    end
  end

  // A same-cycle pop does not free a slot, keeping m_rvalid off the m_req path.
  assign avail     = (count_q < CNT_MAX);
  assign m_req     = anrst & avail & (i_req | d_req);
  assign handshake = m_req & m_gnt;
  assign i_gnt     = handshake & (sel == ID_I);
  assign d_gnt     = handshake & (sel == ID_D);
  assign m_addr    = payload.addr;
  assign m_we      = payload.we;
  assign m_be      = payload.be;
  assign m_wdata   = payload.wdata;

  assign head      = fifo_q[rd_ptr_q];
  assign pop       = anrst & m_rvalid & (count_q != '0);
  assign spurious  = m_rvalid & (count_q == '0);
  assign i_rvalid  = pop & (head == ID_I);
  assign d_rvalid  = pop & (head == ID_D);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

  // ID FIFO, occupancy, round-robin history and sticky error.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      for (int k = 0; k < int'(MAX_OUTSTANDING); k++) fifo_q[k] <= ID_I;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= ID_D;
      err          <= 1'b0;
    end else begin
      if (handshake) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= next_ptr(wr_ptr_q);
        last_grant_q     <= sel;
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({handshake, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (spurious) err <= 1'b1;
    end
  end

`ifdef LADYBIRD_MEM_ARBITER_PERF_EN
  logic stall;
  assign stall = (i_req | d_req) & ~(i_gnt | d_gnt);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (i_gnt && i_grant_cnt != '1) i_grant_cnt <= i_grant_cnt + 32'd1;
      if (d_gnt && d_grant_cnt != '1) d_grant_cnt <= d_grant_cnt + 32'd1;
      if (stall && stall_cnt != '1)   stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ladybird_mem_arbiter.sv
// Directed bench for ladybird_mem_arbiter: inputs change 1 time unit after posedge,
// combinational outputs are checked 1 unit later, registered effects after the next edge.
module tb_ladybird_mem_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned TIMEOUT_NS = 100000;

  logic            clk = 1'b0;
  logic            anrst;
  logic            i_req, i_gnt, i_rvalid;
  logic [XLEN-1:0] i_addr, i_rdata;
  logic            d_req, d_gnt, d_we, d_rvalid;
  logic [3:0]      d_be;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic            m_req, m_gnt, m_we, m_rvalid;
  logic [3:0]      m_be;
  logic [XLEN-1:0] m_addr, m_wdata, m_rdata;
  logic            err;
`ifdef LADYBIRD_MEM_ARBITER_PERF_EN
  logic [31:0]     i_grant_cnt, d_grant_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  ladybird_mem_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .anrst(anrst),
    .i_req(i_req), .i_gnt(i_gnt), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_gnt(d_gnt), .d_addr(d_addr), .d_we(d_we), .d_be(d_be),
    .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_we(m_we), .m_be(m_be),
    .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err(err)
`ifdef LADYBIRD_MEM_ARBITER_PERF_EN
    , .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_be = 4'h0; d_wdata = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  // Watchdog: the stimulus must complete within the time budget.
  initial begin
    #(TIMEOUT_NS);
    if (!done) begin
      errors++;
      $error("FAIL timeout: stimulus did not finish within %0d time units", TIMEOUT_NS);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    // Reset with traffic asserted: every handshake output must stay low.
    anrst = 1'b0;
    idle_inputs();
    i_req = 1'b1; d_req = 1'b1; m_gnt = 1'b1; m_rvalid = 1'b1;
    #2;
    chk("rst_m_req", XLEN'(m_req), XLEN'(1'b0));
    chk("rst_i_gnt", XLEN'(i_gnt), XLEN'(1'b0));
    chk("rst_d_gnt", XLEN'(d_gnt), XLEN'(1'b0));
    chk("rst_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b0));
    chk("rst_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b0));
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $error("FAIL rst_err observed=%0h expected=0", err);
    end
    idle_inputs();
    #1 anrst = 1'b1;
    tick();

    // I only read, response the following cycle.
    i_req = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
    #1;
    chk("i_only_m_req", XLEN'(m_req), XLEN'(1'b1));
    chk("i_only_m_addr", m_addr, 32'h100);
    chk("i_only_m_we", XLEN'(m_we), XLEN'(1'b0));
    chk("i_only_m_be", XLEN'(m_be), XLEN'(4'hF));
    chk("i_only_m_wdata", m_wdata, 32'h0);
    chk("i_only_i_gnt", XLEN'(i_gnt), XLEN'(1'b1));
    chk("i_only_d_gnt", XLEN'(d_gnt), XLEN'(1'b0));
    tick();
    i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
    #1;
    chk("i_only_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b1));
    chk("i_only_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("i_only_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b0));
    chk("i_only_d_rdata", d_rdata, 32'hDEADBEEF);
    tick();

    // Fresh reset so last_grant is D again, then both requesters contend.
    m_rvalid = 1'b0;
    anrst = 1'b0;
    #1 anrst = 1'b1;
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300; m_gnt = 1'b1;
    #1;
    chk("rr1_i_gnt", XLEN'(i_gnt), XLEN'(1'b1));
    chk("rr1_d_gnt", XLEN'(d_gnt), XLEN'(1'b0));
    chk("rr1_m_addr", m_addr, 32'h200);
    tick();
    chk("rr2_d_gnt", XLEN'(d_gnt), XLEN'(1'b1));
    chk("rr2_i_gnt", XLEN'(i_gnt), XLEN'(1'b0));
    chk("rr2_m_addr", m_addr, 32'h300);
    tick();
    chk("full1_m_req", XLEN'(m_req), XLEN'(1'b0));
    chk("full1_i_gnt", XLEN'(i_gnt), XLEN'(1'b0));
    chk("full1_d_gnt", XLEN'(d_gnt), XLEN'(1'b0));
    tick();
    chk("full2_m_req", XLEN'(m_req), XLEN'(1'b0));
    m_rvalid = 1'b1; m_rdata = 32'h11;
    #1;
    chk("full_pop_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b1));
    chk("full_pop_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b0));
    chk("full_pop_same_cycle_m_req", XLEN'(m_req), XLEN'(1'b0));
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("rr3_m_req", XLEN'(m_req), XLEN'(1'b1));
    chk("rr3_i_gnt", XLEN'(i_gnt), XLEN'(1'b1));
    chk("rr3_m_addr", m_addr, 32'h200);
    tick();
    // FIFO now holds D then I.
    i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h22;
    #1;
    chk("drain1_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b1));
    chk("drain1_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b0));
    tick();
    m_rdata = 32'h33;
    #1;
    chk("drain2_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b1));
    chk("drain2_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b0));
    tick();

    // D write followed by I read; responses come back in issue order.
    m_rvalid = 1'b0;
    d_req = 1'b1; d_addr = 32'h400; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'h1234;
    #1;
    chk("dwr_d_gnt", XLEN'(d_gnt), XLEN'(1'b1));
    chk("dwr_m_addr", m_addr, 32'h400);
    chk("dwr_m_we", XLEN'(m_we), XLEN'(1'b1));
    chk("dwr_m_be", XLEN'(m_be), XLEN'(4'b0011));
    chk("dwr_m_wdata", m_wdata, 32'h1234);
    tick();
    d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 32'h500;
    #1;
    chk("ird_i_gnt", XLEN'(i_gnt), XLEN'(1'b1));
    chk("ird_m_we", XLEN'(m_we), XLEN'(1'b0));
    chk("ird_m_be", XLEN'(m_be), XLEN'(4'hF));
    chk("ird_m_wdata", m_wdata, 32'h0);
    tick();
    i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hA;
    #1;
    chk("il1_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b1));
    chk("il1_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b0));
    chk("il1_d_rdata", d_rdata, 32'hA);
    tick();
    m_rdata = 32'hB;
    #1;
    chk("il2_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b1));
    chk("il2_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b0));
    chk("il2_i_rdata", i_rdata, 32'hB);
    tick();
    // Count back at 0: another response is spurious, checked below.

    // Push and pop in the same cycle, exercising pointer wrap.
    m_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h600;
    #1;
    chk("pp_setup_i_gnt", XLEN'(i_gnt), XLEN'(1'b1));
    tick();
    i_req = 1'b0; d_req = 1'b1; d_addr = 32'h700; m_rvalid = 1'b1;
    #1;
    chk("pp_d_gnt", XLEN'(d_gnt), XLEN'(1'b1));
    chk("pp_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b1));
    chk("pp_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b0));
    tick();
    // Count must still be 1: a new I request is accepted while D's response pops.
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h800;
    #1;
    chk("pp_count1_i_gnt", XLEN'(i_gnt), XLEN'(1'b1));
    chk("pp_next_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b1));
    chk("pp_next_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b0));
    tick();
    i_req = 1'b0;
    #1;
    chk("pp_last_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b1));
    chk("pp_last_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b0));
    tick();

    // Spurious response with count==0.
    #1;
    chk("spur_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b0));
    chk("spur_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b0));
    chk("spur_err_before", XLEN'(err), XLEN'(1'b0));
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $error("FAIL spur_err_set observed=%0h expected=1", err);
    end
    m_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h900;
    #1;
    chk("err_arb_i_gnt", XLEN'(i_gnt), XLEN'(1'b1));
    tick();
    i_req = 1'b0; m_rvalid = 1'b1;
    #1;
    chk("err_traffic_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b1));
    tick();
    m_rvalid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $error("FAIL err_sticky observed=%0h expected=1", err);
    end

    // Reset with one request in flight discards its ID; the late response is stale.
    i_req = 1'b1; i_addr = 32'hA00;
    #1;
    chk("mid_i_gnt", XLEN'(i_gnt), XLEN'(1'b1));
    tick();
    i_req = 1'b0;
    anrst = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $error("FAIL mid_rst_err_clear observed=%0h expected=0", err);
    end
    anrst = 1'b1;
    m_rvalid = 1'b1;
    #1;
    chk("stale_i_rvalid", XLEN'(i_rvalid), XLEN'(1'b0));
    chk("stale_d_rvalid", XLEN'(d_rvalid), XLEN'(1'b0));
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $error("FAIL stale_err observed=%0h expected=1", err);
    end
    m_rvalid = 1'b0;
    tick();

    done = 1'b1;
    if (errors != 0) $error("FAIL: %0d of %0d checks failed", errors, checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
